// File: rtl/jpeg_pix_pkg.sv
// Shared pixel/block types for the JPEG pixel back end.
//   BLK_DIM / BLK_PIX : 8x8 block geometry
//   PKG_PIX_W         : colour component width used by the shared types
//   rgb_pix_t         : one RGB pixel
//   blk8_t            : one 8x8 component block, element [7-row][7-col] is image (row,col)
package jpeg_pix_pkg;

  localparam int BLK_DIM   = 8;
  localparam int BLK_PIX   = 64;
  localparam int PKG_PIX_W = 8;

  typedef struct packed {
    logic [PKG_PIX_W-1:0] r;
    logic [PKG_PIX_W-1:0] g;
    logic [PKG_PIX_W-1:0] b;
  } rgb_pix_t;

  typedef logic [BLK_DIM-1:0][BLK_DIM-1:0][PKG_PIX_W-1:0] blk8_t;

endpackage

// File: rtl/rgb_blk_mux.sv
// Combinational pixel selector: picks one RGB pixel out of the block slot array.
//   slot_r/g/b : stored component blocks, one entry per FIFO slot
//   rd_ptr     : slot currently being drained
//   pix_idx    : raster index inside the block (row = [5:3], col = [2:0])
//   pix        : selected pixel
module rgb_blk_mux
  import jpeg_pix_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  blk8_t          slot_r [DEPTH],
  input  blk8_t          slot_g [DEPTH],
  input  blk8_t          slot_b [DEPTH],
  input  logic [PTR_W-1:0] rd_ptr,
  input  logic [5:0]     pix_idx,
  output rgb_pix_t       pix
);

  // Image (row,col) lives at element [7-row][7-col]; for 3-bit fields 7-x == ~x.
  logic [2:0] row_sel;
  logic [2:0] col_sel;

  assign row_sel = ~pix_idx[5:3];
  assign col_sel = ~pix_idx[2:0];

  assign pix.r = slot_r[rd_ptr][row_sel][col_sel];
  assign pix.g = slot_g[rd_ptr][row_sel][col_sel];
  assign pix.b = slot_b[rd_ptr][row_sel][col_sel];

endmodule

// File: rtl/rgb_block_serializer.sv
// Block-deep FIFO that captures whole 8x8 RGB blocks from the colour converter
// and replays them one pixel per cycle, raster order, over a valid/ready stream.
//   clk, rst            : clock, synchronous active-high reset
//   valid_in, r, g, b   : block write (dropped when all slots are full)
//   in_ready            : status, at least one free slot
//   out_valid/out_ready : pixel stream handshake
//   pix_r/g/b           : current pixel (0 when out_valid=0)
//   pix_row/pix_col     : pixel position inside the block
//   pix_blk             : block sequence number mod 4 (MCU quadrant)
//   blk_last            : current pixel is the last of its block
//   overflow            : sticky, a block was dropped
module rgb_block_serializer
  import jpeg_pix_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PIX_W = PKG_PIX_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [7:0][7:0][PIX_W-1:0]   r,
  input  logic [7:0][7:0][PIX_W-1:0]   g,
  input  logic [7:0][7:0][PIX_W-1:0]   b,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PIX_W-1:0]             pix_r,
  output logic [PIX_W-1:0]             pix_g,
  output logic [PIX_W-1:0]             pix_b,
  output logic [2:0]                   pix_row,
  output logic [2:0]                   pix_col,
  output logic [1:0]                   pix_blk,
  output logic                         blk_last,
  output logic                         overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  blk8_t slot_r [DEPTH];
  blk8_t slot_g [DEPTH];
  blk8_t slot_b [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [5:0]       pix_idx;
  logic [1:0]       blk_seq;

  logic     full;
  logic     wr_en;
  logic     xfer;
  logic     pop;
  rgb_pix_t sel_pix;

  // Fullness comes from the registered count only, so a pop in the same
  // cycle cannot make room for an incoming block.
  assign full      = (count == CNT_W'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = (count != '0);
  assign wr_en     = valid_in && !full;
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && (pix_idx == 6'(BLK_PIX - 1));

  // Slot storage carries no reset; reset still blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      slot_r[wr_ptr] <= r;
      slot_g[wr_ptr] <= g;
      slot_b[wr_ptr] <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pix_idx  <= '0;
      blk_seq  <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (valid_in && full) begin
        overflow <= 1'b1;
      end
      if (xfer) begin
        pix_idx <= pix_idx + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        blk_seq <= blk_seq + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  rgb_blk_mux #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mux (
    .slot_r  (slot_r),
    .slot_g  (slot_g),
    .slot_b  (slot_b),
    .rd_ptr  (rd_ptr),
    .pix_idx (pix_idx),
    .pix     (sel_pix)
  );

  assign pix_r    = out_valid ? sel_pix.r : '0;
  assign pix_g    = out_valid ? sel_pix.g : '0;
  assign pix_b    = out_valid ? sel_pix.b : '0;
  assign pix_row  = pix_idx[5:3];
  assign pix_col  = pix_idx[2:0];
  assign pix_blk  = blk_seq;
  assign blk_last = out_valid && (pix_idx == 6'(BLK_PIX - 1));

endmodule

// File: doc/rgb_block_serializer.md
Name: rgb_block_serializer

Overview:
- Sits directly downstream of sup_buf_ycbcr2rgb.
- Captures each 8x8 RGB block presented on valid_out/r/g/b into a block-deep FIFO.
- Replays the stored pixels one per cycle, in raster order within the block, over a valid/ready stream to the image writer.
- Absorbs the back-to-back 4-block bursts of one 4:2:0 MCU while the sink stalls.

Parameters:
- DEPTH, 4: number of 8x8 RGB block slots. Power of two, at least 2.
- PIX_W, 8: bits per colour component.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  a block is present on r/g/b this cycle; connects to upstream valid_out
- r  in  PIX_W x [7:0][7:0]  red block
- g  in  PIX_W x [7:0][7:0]  green block
- b  in  PIX_W x [7:0][7:0]  blue block
- in_ready  out  1  at least one free slot (count < DEPTH); status only, upstream does not stall
- out_valid  out  1  pixel available
- out_ready  in  1  sink accepts pixel
- pix_r, pix_g, pix_b  out  PIX_W each  current pixel
- pix_row, pix_col  out  3 each  pixel position inside its block
- pix_blk  out  2  block sequence number, mod 4, of the block being drained (MCU quadrant)
- blk_last  out  1  current pixel is pixel 63 of its block
- overflow  out  1  sticky: a block was dropped

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, pix_idx=0, blk_seq=0, overflow=0.
  - Resulting outputs: out_valid=0, pix_*=0, pix_row=0, pix_col=0, pix_blk=0, blk_last=0, in_ready=1.
  - Slot contents are not reset.
- Array orientation: image pixel (row,col) of a block is array element [7-row][7-col]. Element [7][7] is the top-left pixel, which is the first value loaded by upstream.
- Write:
  - If valid_in && count<DEPTH at a posedge, all 64 pixels of r/g/b are stored into slot wr_ptr and wr_ptr increments, wrapping mod DEPTH.
- Drop:
  - If valid_in && count==DEPTH, the block is discarded and overflow is set; it stays set until rst.
  - A pop occurring in the same cycle does not rescue the block; in_ready is decided from registered count.
- Read:
  - out_valid = (count>0), combinational from registered state.
  - pix_idx (6 bits) gives pix_row = pix_idx[5:3] and pix_col = pix_idx[2:0].
  - pix_r/g/b = slot[rd_ptr] element [7-pix_row][7-pix_col]. Driven 0 when out_valid=0.
  - blk_last = out_valid && pix_idx==63.
  - pix_blk = blk_seq.
- Handshake:
  - A pixel transfers on a posedge with out_valid && out_ready; pix_idx then increments.
  - On transfer with pix_idx==63: pix_idx wraps to 0, rd_ptr increments mod DEPTH, blk_seq increments mod 4, and the slot is freed.
  - out_valid=1 with out_ready=0 holds every output stable.
  - Asserting out_ready while out_valid=0 has no effect.
- Count update: +1 on accepted write, -1 on freeing pop. Both in one cycle leave count unchanged.
- Latency: a block accepted at posedge N produces its first pixel with out_valid=1 in the cycle after edge N, when the FIFO was empty. Throughput is 1 pixel/cycle; a block drains in 64 accepted cycles.
- Reset mid-operation: rst at any edge overrides writes and pops. The FIFO empties, partially drained blocks are lost, and overflow clears.

Decomposition:
- Package jpeg_pix_pkg holds:
  - constants BLK_DIM=8 and BLK_PIX=64;
  - typedef rgb_pix_t, a struct of r, g, b at PIX_W;
  - typedef blk8_t, PIX_W x [7:0][7:0].
- One sub-module is natural: rgb_blk_mux, a combinational selector from slot array + rd_ptr + pix_idx to rgb_pix_t.
- FIFO control and counters stay in the top module.

Test Plan:
- Single block ramp:
  - Stimulus: element [i][j]=i*8+j on r, +1 on g, +2 on b; out_ready=1.
  - Expected: out_valid rises the cycle after write; 64 pixels follow with pix_r = 63,62,...,0, rows/cols counting 0..7, and blk_last only on the 64th pixel.
- MCU burst with stalled sink:
  - Stimulus: 4 distinct constant blocks (0x11, 0x22, 0x33, 0x44) on consecutive cycles with out_ready=0; then out_ready=1.
  - Expected: in_ready=0 after the 4th write; 256 pixels emerge in order with pix_blk 0,1,2,3; overflow stays 0.
- Overflow:
  - Stimulus: 5 consecutive blocks into DEPTH=4 with out_ready=0.
  - Expected: overflow=1 from the 5th edge; only blocks 1-4 are emitted; the 5th value (0x55) never appears.
- Backpressure:
  - Stimulus: toggle out_ready every cycle during a block.
  - Expected: outputs hold while out_ready=0; all 64 pixels are delivered exactly once in order.
- Simultaneous write and last pop:
  - Stimulus: with count=DEPTH, accept pixel 63 while valid_in=1.
  - Expected: the new block is dropped, overflow=1, count becomes DEPTH-1.
  - Stimulus: with count=2, the same event.
  - Expected: count stays 2.
- Reset mid-drain:
  - Stimulus: rst=1 for one cycle at pixel 20 of block 0 with 2 blocks queued.
  - Expected: next cycle out_valid=0, in_ready=1, overflow=0; a new block then drains starting at pixel 0 with pix_blk=0.
